gray_updown_counter: RTL and testbench
======================================

GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits, legal range >= 2.
REQ-002 SHALL have parameter SATURATE, default 0: 0 = wrap at bounds, 1 = clamp at bounds.
REQ-003 SHALL have parameter FAST_NOT_SMALL, default 0: 0 = state held as gray only; 1 = binary shadow register plus gray register.
REQ-004 SHALL have port i_clk, input, 1, sole clock; all state on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_cg, input, 1, clock-gate enable; when low, all state holds.
REQ-007 SHALL have port i_incr, input, 1, request count up by one.
REQ-008 SHALL have port i_decr, input, 1, request count down by one.
REQ-009 SHALL have port i_load, input, 1, request load of i_loadBin.
REQ-010 SHALL have port i_loadBin, input, WIDTH, binary value to load.
REQ-011 SHALL have port o_gray, output, WIDTH, registered gray-coded count.
REQ-012 SHALL have port o_bin, output, WIDTH, binary equivalent of o_gray.
REQ-013 SHALL have port o_isZero, output, 1, high when count == 0.
REQ-014 SHALL have port o_isMax, output, 1, high when count == 2**WIDTH-1.
REQ-015 SHALL have port o_wrap, output, 1, registered one-cycle bound-crossing pulse.

Function
REQ-016 SHALL evaluate per cycle with priority i_rst > !i_cg (hold) > i_load > (i_incr & i_decr: hold) > i_incr > i_decr > hold.
REQ-017 SHALL update o_gray exactly one cycle after an accepted request, for both FAST_NOT_SMALL values; no extra latency in FAST mode.
REQ-018 SHALL keep o_gray = (bin >> 1) ^ bin for the internal binary count at all times.
REQ-019 SHALL change at most one bit of o_gray per cycle except on load or reset.
REQ-020 SHALL derive o_bin, o_isZero, o_isMax combinationally from registered state: from gray prefix-XOR when FAST_NOT_SMALL=0, from the shadow register when 1.
REQ-021 SHALL, with SATURATE=0, wrap incr at max to 0 and decr at 0 to max.
REQ-022 SHALL, with SATURATE=1, hold at max on incr and at 0 on decr.
REQ-023 SHALL load i_loadBin converted to gray on i_load; i_incr/i_decr ignored that cycle.
REQ-024 SHALL treat i_incr & i_decr simultaneously as no change and no wrap event.

Reset
REQ-025 SHALL on i_rst high at a rising edge set count to 0 (o_gray=0, o_bin=0, o_isZero=1, o_isMax=0, o_wrap=0) regardless of i_cg, i_load, i_incr, i_decr.
REQ-026 SHALL let reset asserted mid-operation override any in-flight request that cycle; counting resumes from 0 on the first cycle after deassertion.

Configuration
REQ-027 SHALL compile o_wrap logic only when macro GRAY_UPDOWN_COUNTER_WRAP_EN is defined.
REQ-028 SHALL, with GRAY_UPDOWN_COUNTER_WRAP_EN defined, pulse o_wrap high for exactly one cycle, one cycle after an accepted incr at max or decr at 0 (either SATURATE value); not on load, hold, or simultaneous incr/decr.
REQ-029 SHALL, without GRAY_UPDOWN_COUNTER_WRAP_EN, tie o_wrap to 0 and add no o_wrap register; all other behaviour is identical.

Verification (WIDTH=4, both FAST_NOT_SMALL values)
REQ-030 SHALL cover reset then 16 cycles of i_incr -> o_gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; o_bin 0..15,0; single-bit gray change each step.
REQ-031 SHALL cover SATURATE=0: count 15 plus i_incr -> o_bin=0 and o_wrap=1 one cycle later (macro defined); count 0 plus i_decr -> o_bin=15, o_gray=8.
REQ-032 SHALL cover SATURATE=1: count 15 plus i_incr for 3 cycles -> o_bin stays 15, o_isMax=1, o_wrap=1 each cycle (macro defined).
REQ-033 SHALL cover i_load=1, i_loadBin=9, i_incr=1 -> next cycle o_bin=9, o_gray=D; then i_incr=i_decr=1 -> holds 9, o_wrap=0.
REQ-034 SHALL cover count 5 with i_cg=0 and i_incr=1 for 4 cycles -> holds 5; then i_rst=1 with i_cg=0 -> next cycle o_bin=0, o_isZero=1.
REQ-035 SHALL cover the build without GRAY_UPDOWN_COUNTER_WRAP_EN repeating REQ-031 -> identical count values, o_wrap constantly 0.

Source files
------------

// File: rtl/gray_updown_counter.sv
// Up/down gray-code counter with optional saturation and an optional binary shadow register.
// Define GRAY_UPDOWN_COUNTER_WRAP_EN to build the registered o_wrap bound-crossing pulse.
module gray_updown_counter #(
   parameter int WIDTH          = 8,
   parameter int SATURATE       = 0,
   parameter int FAST_NOT_SMALL = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cg,
   input  logic             i_incr,
   input  logic             i_decr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_loadBin,
   output logic [WIDTH-1:0] o_gray,
   output logic [WIDTH-1:0] o_bin,
   output logic             o_isZero,
   output logic             o_isMax,
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = '1;

   logic [WIDTH-1:0] gray_q;
   logic [WIDTH-1:0] gray_d;
   logic [WIDTH-1:0] bin_d;
   logic [WIDTH-1:0] cur_bin;
   logic             incr_only;
   logic             decr_only;
   logic             at_max;
   logic             at_zero;

   assign incr_only = i_incr & ~i_decr & ~i_load;
   assign decr_only = i_decr & ~i_incr & ~i_load;
   assign at_max    = (cur_bin == MAX_VAL);
   assign at_zero   = (cur_bin == '0);

   // Next binary value; reset and clock-gate are applied at the register.
   always_comb begin
      bin_d = cur_bin;
      if (i_load) begin
         bin_d = i_loadBin;
      end else if (incr_only) begin
         if (at_max) begin
            bin_d = (SATURATE != 0) ? MAX_VAL : '0;
         end else begin
            bin_d = cur_bin + 1'b1;
         end
      end else if (decr_only) begin
         if (at_zero) begin
            bin_d = (SATURATE != 0) ? '0 : MAX_VAL;
         end else begin
            bin_d = cur_bin - 1'b1;
         end
      end
      gray_d = bin_d ^ (bin_d >> 1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gray_q <= '0;
      end else if (i_cg) begin
         gray_q <= gray_d;
      end
   end

   generate
      if (FAST_NOT_SMALL != 0) begin : g_fast
         logic [WIDTH-1:0] bin_q;

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               bin_q <= '0;
            end else if (i_cg) begin
               bin_q <= bin_d;
            end
         end

         assign cur_bin = bin_q;
      end else begin : g_small
         // Each binary bit is the XOR of all gray bits at or above it.
         for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign cur_bin[gi] = ^gray_q[WIDTH-1:gi];
         end
      end
   endgenerate

   assign o_gray   = gray_q;
   assign o_bin    = cur_bin;
   assign o_isZero = at_zero;
   assign o_isMax  = at_max;

`ifdef GRAY_UPDOWN_COUNTER_WRAP_EN
   logic wrap_q;
   logic wrap_d;

   // Pulses for any accepted bound crossing, including a clamped one.
   always_comb begin
      wrap_d = i_cg & ((incr_only & at_max) | (decr_only & at_zero));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign o_wrap = wrap_q;
`else
   assign o_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: four WIDTH=4 instances (SATURATE x FAST_NOT_SMALL) against a counting model.
module tb_gray_updown_counter;

   logic       clk;
   logic       i_rst, i_cg, i_incr, i_decr, i_load;
   logic [3:0] i_loadBin;
   logic [3:0] gray_o [4];
   logic [3:0] bin_o  [4];
   logic       zero_o [4];
   logic       max_o  [4];
   logic       wrap_o [4];

   int n_vec = 0;
   int n_err = 0;

   // Model state per SATURATE value: plain integer count and expected wrap pulse.
   int  m_cnt  [2];
   bit  m_wrap [2];
   bit  wrap_en;
   bit  last_jump;
   logic [3:0] gseq [16];
   logic [3:0] prev_gray [4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dut
         gray_updown_counter #(
            .WIDTH(4),
            .SATURATE(gi / 2),
            .FAST_NOT_SMALL(gi % 2)
         ) u_dut (
            .i_clk(clk),
            .i_rst(i_rst),
            .i_cg(i_cg),
            .i_incr(i_incr),
            .i_decr(i_decr),
            .i_load(i_load),
            .i_loadBin(i_loadBin),
            .o_gray(gray_o[gi]),
            .o_bin(bin_o[gi]),
            .o_isZero(zero_o[gi]),
            .o_isMax(max_o[gi]),
            .o_wrap(wrap_o[gi])
         );
      end
   endgenerate

   // Apply one cycle of inputs, advance the model, and return at the next falling edge.
   task automatic step(input bit rst, input bit cg, input bit load, input logic [3:0] lb,
                       input bit inc, input bit dec);
      for (int k = 0; k < 4; k++) prev_gray[k] = gray_o[k];
      i_rst = rst; i_cg = cg; i_load = load; i_loadBin = lb; i_incr = inc; i_decr = dec;
      last_jump = rst | (cg & load);
      for (int s = 0; s < 2; s++) begin
         bit w;
         w = 1'b0;
         if (rst) begin
            m_cnt[s] = 0;
         end else if (cg) begin
            if (load) begin
               m_cnt[s] = int'(lb);
            end else if (inc && !dec) begin
               if (m_cnt[s] == 15) begin
                  w = 1'b1;
                  m_cnt[s] = (s == 1) ? 15 : 0;
               end else begin
                  m_cnt[s] = m_cnt[s] + 1;
               end
            end else if (dec && !inc) begin
               if (m_cnt[s] == 0) begin
                  w = 1'b1;
                  m_cnt[s] = (s == 1) ? 0 : 15;
               end else begin
                  m_cnt[s] = m_cnt[s] - 1;
               end
            end
         end
         m_wrap[s] = w & wrap_en;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(1, 0, 1, 4'h7, 1, 1);
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (gray_o[k] !== 4'h0 || bin_o[k] !== 4'h0 || zero_o[k] !== 1'b1 ||
             max_o[k] !== 1'b0 || wrap_o[k] !== 1'b0) begin
            n_err++;
            $display("FAIL reset inst%0d: gray=%h bin=%h zero=%b max=%b wrap=%b, required 0 0 1 0 0",
                     k, gray_o[k], bin_o[k], zero_o[k], max_o[k], wrap_o[k]);
         end
      end
      $display("reset: gray=%h bin=%h zero=%b", gray_o[0], bin_o[0], zero_o[0]);
   endtask

   task automatic test_incr_sequence();
      for (int i = 1; i <= 16; i++) begin
         step(0, 1, 0, 4'h0, 1, 0);
         for (int k = 0; k < 4; k++) begin
            int eb;
            eb = (k / 2 == 1 && i == 16) ? 15 : i % 16;
            n_vec++;
            if (bin_o[k] !== 4'(eb) || gray_o[k] !== gseq[eb] ||
                $countones(gray_o[k] ^ prev_gray[k]) > 1) begin
               n_err++;
               $display("FAIL incr_seq step%0d inst%0d: gray=%h bin=%h, required gray=%h bin=%h one-bit change",
                        i, k, gray_o[k], bin_o[k], gseq[eb], eb);
            end
         end
         $display("incr step %0d: gray=%h bin=%h", i, gray_o[0], bin_o[0]);
      end
   endtask

   task automatic test_bounds();
      step(0, 1, 1, 4'hF, 0, 0);
      for (int i = 0; i < 4; i++) begin
         if (i < 3) step(0, 1, 0, 4'h0, 1, 0);
         else       step(0, 1, 1, 4'h0, 0, 0);
         for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (bin_o[k] !== 4'(m_cnt[k/2]) || gray_o[k] !== gseq[m_cnt[k/2]] ||
                max_o[k] !== (m_cnt[k/2] == 15) || wrap_o[k] !== m_wrap[k/2]) begin
               n_err++;
               $display("FAIL bound_incr%0d inst%0d: bin=%h max=%b wrap=%b, required bin=%h max=%b wrap=%b",
                        i, k, bin_o[k], max_o[k], wrap_o[k], m_cnt[k/2], m_cnt[k/2] == 15, m_wrap[k/2]);
            end
         end
         $display("bounds incr %0d: sat0 bin=%h wrap=%b sat1 bin=%h wrap=%b",
                  i, bin_o[0], wrap_o[0], bin_o[2], wrap_o[2]);
      end
      step(0, 1, 0, 4'h0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (bin_o[k] !== 4'(m_cnt[k/2]) || gray_o[k] !== gseq[m_cnt[k/2]] ||
             zero_o[k] !== (m_cnt[k/2] == 0) || wrap_o[k] !== m_wrap[k/2]) begin
            n_err++;
            $display("FAIL bound_decr inst%0d: bin=%h gray=%h wrap=%b, required bin=%h gray=%h wrap=%b",
                     k, bin_o[k], gray_o[k], wrap_o[k], m_cnt[k/2], gseq[m_cnt[k/2]], m_wrap[k/2]);
         end
      end
      $display("bounds decr: sat0 bin=%h gray=%h sat1 bin=%h", bin_o[0], gray_o[0], bin_o[2]);
   endtask

   task automatic test_load_and_both();
      for (int i = 0; i < 2; i++) begin
         if (i == 0) step(0, 1, 1, 4'h9, 1, 0);
         else        step(0, 1, 0, 4'h0, 1, 1);
         for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (bin_o[k] !== 4'h9 || gray_o[k] !== 4'hD || wrap_o[k] !== 1'b0) begin
               n_err++;
               $display("FAIL load_both%0d inst%0d: bin=%h gray=%h wrap=%b, required 9 d 0",
                        i, k, bin_o[k], gray_o[k], wrap_o[k]);
            end
         end
         $display("load/both %0d: bin=%h gray=%h wrap=%b", i, bin_o[0], gray_o[0], wrap_o[0]);
      end
   endtask

   task automatic test_cg_hold_reset();
      step(0, 1, 1, 4'h5, 0, 0);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) step(0, 0, 0, 4'h0, 1, 0);
         else       step(1, 0, 0, 4'h0, 1, 0);
         for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (bin_o[k] !== ((i < 4) ? 4'h5 : 4'h0) || zero_o[k] !== (i == 4) ||
                gray_o[k] !== ((i < 4) ? 4'h7 : 4'h0)) begin
               n_err++;
               $display("FAIL cg_hold%0d inst%0d: bin=%h gray=%h zero=%b, required bin=%h",
                        i, k, bin_o[k], gray_o[k], zero_o[k], (i < 4) ? 5 : 0);
            end
         end
         $display("cg hold %0d: bin=%h zero=%b", i, bin_o[0], zero_o[0]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (bin_o[k] !== 4'(m_cnt[k/2]) || gray_o[k] !== gseq[m_cnt[k/2]] ||
                zero_o[k] !== (m_cnt[k/2] == 0) || max_o[k] !== (m_cnt[k/2] == 15) ||
                wrap_o[k] !== m_wrap[k/2] ||
                (!last_jump && $countones(gray_o[k] ^ prev_gray[k]) > 1)) begin
               n_err++;
               $display("FAIL random%0d inst%0d: bin=%h gray=%h z=%b m=%b w=%b, required bin=%h gray=%h w=%b",
                        i, k, bin_o[k], gray_o[k], zero_o[k], max_o[k], wrap_o[k],
                        m_cnt[k/2], gseq[m_cnt[k/2]], m_wrap[k/2]);
            end
         end
         $display("random %0d: rst=%b cg=%b ld=%b inc=%b dec=%b -> sat0 bin=%h sat1 bin=%h",
                  i, i_rst, i_cg, i_load, i_incr, i_decr, bin_o[0], bin_o[2]);
      end
   endtask

   initial begin
`ifdef GRAY_UPDOWN_COUNTER_WRAP_EN
      wrap_en = 1'b1;
`else
      wrap_en = 1'b0;
`endif
      gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
      m_cnt  = '{0, 0};
      m_wrap = '{1'b0, 1'b0};
      last_jump = 1'b1;
      i_rst = 1'b1; i_cg = 1'b0; i_load = 1'b0; i_loadBin = 4'h0; i_incr = 1'b0; i_decr = 1'b0;
      @(negedge clk);
      test_reset();
      test_incr_sequence();
      test_reset();
      test_bounds();
      test_load_and_both();
      test_cg_hold_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
